// File: rtl/xif_coproc_pkg.sv
// Shared types for the XIF coprocessor commit queue.
// Entry layout and small elaboration helpers.
package xif_coproc_pkg;

  localparam int XIF_NUM_RS   = 2;
  localparam int XIF_ID_WIDTH = 4;
  localparam int XIF_RD_W     = 5;

  typedef struct packed {
    logic [31:0]              instr;
    logic [XIF_ID_WIDTH-1:0]  id;
    logic [XIF_NUM_RS*32-1:0] rs;
    logic                     writeback;
    logic                     committed;
    logic                     killed;
  } cq_entry_t;

  function automatic int cq_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xif_result_slice.sv
// Single-entry register between the execution unit
// and the XIF result channel.
module xif_result_slice
  import xif_coproc_pkg::*;
#(
  parameter int ID_W = XIF_ID_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [ID_W-1:0]     in_id_i,
  input  logic [31:0]         in_data_i,
  input  logic [XIF_RD_W-1:0] in_rd_i,
  input  logic                in_we_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ID_W-1:0]     out_id_o,
  output logic [31:0]         out_data_o,
  output logic [XIF_RD_W-1:0] out_rd_o,
  output logic                out_we_o
);

  logic                valid_q, valid_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [31:0]         data_q, data_d;
  logic [XIF_RD_W-1:0] rd_q, rd_d;
  logic                we_q, we_d;
  logic                load;

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    data_d  = data_q;
    rd_d    = rd_q;
    we_d    = we_q;
    if (load) begin
      valid_d = 1'b1;
      id_d    = in_id_i;
      data_d  = in_data_i;
      rd_d    = in_rd_i;
      we_d    = in_we_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_id_o    = id_q;
  assign out_data_o  = data_q;
  assign out_rd_o    = rd_q;
  assign out_we_o    = we_q;

endmodule

// File: rtl/xif_coproc_commit_queue.sv
// In-order issue buffer that waits for XIF commit/kill,
// dispatches committed work and registers its results.
module xif_coproc_commit_queue
  import xif_coproc_pkg::*;
#(
  parameter int X_NUM_RS   = XIF_NUM_RS,
  parameter int X_ID_WIDTH = XIF_ID_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic [31:0]             issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]   issue_id_i,
  input  logic [X_NUM_RS*32-1:0]  issue_rs_i,
  input  logic [X_NUM_RS-1:0]     issue_rs_valid_i,
  input  logic                    dec_accept_i,
  input  logic                    dec_writeback_i,
  input  logic                    commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]   commit_id_i,
  input  logic                    commit_kill_i,
  output logic                    ex_valid_o,
  input  logic                    ex_ready_i,
  output logic [31:0]             ex_instr_o,
  output logic [X_ID_WIDTH-1:0]   ex_id_o,
  output logic [X_NUM_RS*32-1:0]  ex_rs_o,
  input  logic                    ex_res_valid_i,
  output logic                    ex_res_ready_o,
  input  logic [X_ID_WIDTH-1:0]   ex_res_id_i,
  input  logic [31:0]             ex_res_data_i,
  input  logic [4:0]              ex_res_rd_i,
  input  logic                    ex_res_we_i,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic [X_ID_WIDTH-1:0]   result_id_o,
  output logic [31:0]             result_data_o,
  output logic [4:0]              result_rd_o,
  output logic                    result_we_o
);

  localparam int PTR_W = cq_log2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cq_entry_t        ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cq_entry_t        head_e;
  cq_entry_t        new_e;
  logic             head_vld;
  logic             full;
  logic             enq;
  logic             pop;
  logic             kill_pop;
  logic [DEPTH-1:0] cmt_hit;

  assign full          = (cnt_q == CNT_W'(DEPTH));
  assign issue_ready_o = !full && (&issue_rs_valid_i);
  assign enq           = issue_valid_i && issue_ready_o && dec_accept_i;

  assign head_e   = ent_q[head_q];
  assign head_vld = vld_q[head_q];

  assign ex_valid_o = head_vld && head_e.committed && !head_e.killed;
  assign kill_pop   = head_vld && head_e.committed && head_e.killed;
  assign pop        = kill_pop || (ex_valid_o && ex_ready_i);

  assign ex_instr_o = ex_valid_o ? head_e.instr : '0;
  assign ex_id_o    = ex_valid_o ? head_e.id    : '0;
  assign ex_rs_o    = ex_valid_o ? head_e.rs    : '0;

  // Only live, still-pending entries may take a commit.
  always_comb begin
    cmt_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmt_hit[i] = commit_valid_i && vld_q[i] &&
                   !ent_q[i].committed &&
                   (ent_q[i].id == commit_id_i);
    end
  end

  always_comb begin
    new_e           = '0;
    new_e.instr     = issue_instr_i;
    new_e.id        = issue_id_i;
    new_e.rs        = issue_rs_i;
    new_e.writeback = dec_writeback_i;
    new_e.committed = commit_valid_i &&
                      (commit_id_i == issue_id_i);
    new_e.killed    = new_e.committed && commit_kill_i;
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop) head_d = head_q + PTR_W'(1);
    if (enq) tail_d = tail_q + PTR_W'(1);
    unique case ({enq, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cmt_hit[i]) begin
          ent_q[i].committed <= 1'b1;
          ent_q[i].killed    <= commit_kill_i;
        end
      end
      if (pop) vld_q[head_q] <= 1'b0;
      if (enq) begin
        ent_q[tail_q] <= new_e;
        vld_q[tail_q] <= 1'b1;
      end
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  xif_result_slice #(
    .ID_W (X_ID_WIDTH)
  ) u_res (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (ex_res_valid_i),
    .in_ready_o  (ex_res_ready_o),
    .in_id_i     (ex_res_id_i),
    .in_data_i   (ex_res_data_i),
    .in_rd_i     (ex_res_rd_i),
    .in_we_i     (ex_res_we_i),
    .out_valid_o (result_valid_o),
    .out_ready_i (result_ready_i),
    .out_id_o    (result_id_o),
    .out_data_o  (result_data_o),
    .out_rd_o    (result_rd_o),
    .out_we_o    (result_we_o)
  );

endmodule
